// File: rtl/twofish_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// twofish_seq_ctrl_pkg
// Shared definitions for the Twofish sequencer: FSM state encoding, round and
// key-schedule sizes, subkey base offsets and the round-index helper.
// ---------------------------------------------------------------------------
package twofish_seq_ctrl_pkg;

   localparam int unsigned NUM_ROUNDS    = 16;
   localparam int unsigned NUM_KEY_PAIRS = 20;

   // Subkey base offsets: input whitening K0..K3, output whitening K4..K7,
   // round keys start at K8.
   localparam logic [5:0] KEY_BASE_WIN   = 6'd0;
   localparam logic [5:0] KEY_BASE_WOUT  = 6'd4;
   localparam logic [5:0] KEY_BASE_ROUND = 6'd8;

   // Terminal counter values, sized to the counters they are compared with.
   localparam logic [4:0] KG_LAST  = 5'(NUM_KEY_PAIRS - 1);
   localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_KEYGEN     = 3'd1,
      ST_WHITEN_IN  = 3'd2,
      ST_ROUND      = 3'd3,
      ST_WHITEN_OUT = 3'd4,
      ST_DONE       = 3'd5
   } state_t;

   // Decryption walks the round keys backwards; the counter itself always
   // counts up so the terminal test is mode-independent.
   function automatic logic [3:0] rnd_index(input logic [3:0] cnt, input logic dec);
      logic [3:0] idx;
      if (dec) begin
         idx = RND_LAST - cnt;
      end else begin
         idx = cnt;
      end
      return idx;
   endfunction

endpackage

// File: rtl/twofish_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// twofish_seq_ctrl_if
// Panel-request and datapath-control bundle of the Twofish sequencer.
//   button/decrypt/key_new : requests from the top level into the sequencer
//   kg_en/kg_idx           : key generator step enable and subkey pair index
//   load_en                : load block register and apply input whitening
//   rnd_en/rnd_idx         : round unit enable and round number
//   wout_en                : final swap undo + output whitening
//   busy/out_valid         : status
// master = requester side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface twofish_seq_ctrl_if;
   logic       button;
   logic       decrypt;
   logic       key_new;
   logic       kg_en;
   logic [4:0] kg_idx;
   logic       load_en;
   logic       rnd_en;
   logic [3:0] rnd_idx;
   logic       wout_en;
   logic       busy;
   logic       out_valid;

   modport master (
      output button, decrypt, key_new,
      input  kg_en, kg_idx, load_en, rnd_en, rnd_idx, wout_en, busy, out_valid
   );

   modport slave (
      input  button, decrypt, key_new,
      output kg_en, kg_idx, load_en, rnd_en, rnd_idx, wout_en, busy, out_valid
   );
endinterface

// File: rtl/twofish_seq_ctrl_btn_edge.sv
// ---------------------------------------------------------------------------
// twofish_seq_ctrl_btn_edge
// Rising-edge detector for an already synchronised panel level.
//   clk     in  system clock
//   reset   in  synchronous, active-low
//   level_i in  panel level
//   rise_o  out one-cycle pulse in the cycle level_i is high and was low
// ---------------------------------------------------------------------------
module twofish_seq_ctrl_btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   output logic rise_o
);

   logic btn_q;
   logic btn_d;

   // Previous-level capture.
   always_comb begin
      btn_d = level_i;
   end

   // Previous-level register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         btn_q <= 1'b0;
      end else begin
         btn_q <= btn_d;
      end
   end

   assign rise_o = level_i & ~btn_q;

endmodule

// File: rtl/twofish_seq_ctrl.sv
// ---------------------------------------------------------------------------
// twofish_seq_ctrl
// Sequencer for the Twofish datapath. One start per button press; steps the
// key generator through 20 subkey pairs (only when the key is new or not yet
// expanded), then input whitening, 16 rounds and output whitening.
//   clk   in  system clock, rising edge
//   reset in  synchronous, active-low
//   bus   slave modport of twofish_seq_ctrl_if (requests in, strobes/status out)
// All outputs are registered; they are decoded from the next-state values so
// they line up with the state they describe.
// ---------------------------------------------------------------------------
module twofish_seq_ctrl
   import twofish_seq_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   twofish_seq_ctrl_if.slave    bus
);

   state_t     state_q,   state_d;
   logic [4:0] kg_cnt_q,  kg_cnt_d;
   logic [3:0] rnd_cnt_q, rnd_cnt_d;
   logic       dec_q,     dec_d;
   logic       key_ok_q,  key_ok_d;

   logic       kg_en_q,     kg_en_d;
   logic [4:0] kg_idx_q,    kg_idx_d;
   logic       load_en_q,   load_en_d;
   logic       rnd_en_q,    rnd_en_d;
   logic [3:0] rnd_idx_q,   rnd_idx_d;
   logic       wout_en_q,   wout_en_d;
   logic       busy_q,      busy_d;
   logic       out_valid_q, out_valid_d;

   logic       start_s;

   twofish_seq_ctrl_btn_edge u_btn_edge (
      .clk     (clk),
      .reset   (reset),
      .level_i (bus.button),
      .rise_o  (start_s)
   );

   // Next-state, counter and mode/key bookkeeping.
   always_comb begin
      state_d   = state_q;
      kg_cnt_d  = 5'd0;
      rnd_cnt_d = 4'd0;
      dec_d     = dec_q;
      key_ok_d  = key_ok_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Start edges are only seen here, so presses during a run are dropped.
            if (start_s) begin
               dec_d = bus.decrypt;
               if (!key_ok_q || bus.key_new) begin
                  state_d = ST_KEYGEN;
               end else begin
                  state_d = ST_WHITEN_IN;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_KEYGEN: begin
            if (kg_cnt_q == KG_LAST) begin
               key_ok_d = 1'b1;
               state_d  = ST_WHITEN_IN;
            end else begin
               kg_cnt_d = kg_cnt_q + 5'd1;
            end
         end
         ST_WHITEN_IN: begin
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            if (rnd_cnt_q == RND_LAST) begin
               state_d = ST_WHITEN_OUT;
            end else begin
               rnd_cnt_d = rnd_cnt_q + 4'd1;
            end
         end
         ST_WHITEN_OUT: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from next state; indices forced to 0 when not enabled.
   always_comb begin
      kg_en_d     = (state_d == ST_KEYGEN);
      load_en_d   = (state_d == ST_WHITEN_IN);
      rnd_en_d    = (state_d == ST_ROUND);
      wout_en_d   = (state_d == ST_WHITEN_OUT);
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
      out_valid_d = (state_d == ST_DONE);
      if (kg_en_d) begin
         kg_idx_d = kg_cnt_d;
      end else begin
         kg_idx_d = 5'd0;
      end
      if (rnd_en_d) begin
         rnd_idx_d = rnd_index(rnd_cnt_d, dec_d);
      end else begin
         rnd_idx_d = 4'd0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         kg_cnt_q    <= 5'd0;
         rnd_cnt_q   <= 4'd0;
         dec_q       <= 1'b0;
         key_ok_q    <= 1'b0;
         kg_en_q     <= 1'b0;
         kg_idx_q    <= 5'd0;
         load_en_q   <= 1'b0;
         rnd_en_q    <= 1'b0;
         rnd_idx_q   <= 4'd0;
         wout_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         kg_cnt_q    <= kg_cnt_d;
         rnd_cnt_q   <= rnd_cnt_d;
         dec_q       <= dec_d;
         key_ok_q    <= key_ok_d;
         kg_en_q     <= kg_en_d;
         kg_idx_q    <= kg_idx_d;
         load_en_q   <= load_en_d;
         rnd_en_q    <= rnd_en_d;
         rnd_idx_q   <= rnd_idx_d;
         wout_en_q   <= wout_en_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.kg_en     = kg_en_q;
   assign bus.kg_idx    = kg_idx_q;
   assign bus.load_en   = load_en_q;
   assign bus.rnd_en    = rnd_en_q;
   assign bus.rnd_idx   = rnd_idx_q;
   assign bus.wout_en   = wout_en_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_twofish_seq_ctrl.sv
module tb_twofish_seq_ctrl;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   twofish_seq_ctrl_if bus_if ();

   twofish_seq_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed outputs packed: kg_en, kg_idx[4:0], load_en, rnd_en, rnd_idx[3:0], wout_en, busy, out_valid
   function automatic logic [14:0] obs();
      return {bus_if.kg_en, bus_if.kg_idx, bus_if.load_en, bus_if.rnd_en,
              bus_if.rnd_idx, bus_if.wout_en, bus_if.busy, bus_if.out_valid};
   endfunction

   function automatic logic [14:0] pack_exp(input logic kg, input logic [4:0] kgi,
                                            input logic ld, input logic rn,
                                            input logic [3:0] rni, input logic wo,
                                            input logic bz, input logic ov);
      return {kg, kgi, ld, rn, rni, wo, bz, ov};
   endfunction

   // Presses the button and follows one run cycle by cycle. m counts edges
   // after the edge that sees the press (m=0 is the first cycle of the run).
   task automatic observe_run(input bit with_kg, input bit dec, input int toggle_at,
                              input bit repress, input int stop_m, input string tag);
      int base;
      int last;
      int r;
      logic [14:0] e;
      logic [14:0] a;
      base = with_kg ? 20 : 0;
      last = base + 18;
      if (stop_m < last) last = stop_m;
      bus_if.button = 1'b1;
      for (int m = 0; m <= last; m++) begin
         @(posedge clk); #1;
         if (m < base) begin
            e = pack_exp(1'b1, 5'(m), 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
         end else if (m == base) begin
            e = pack_exp(1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
         end else if (m <= base + 16) begin
            r = m - base - 1;
            e = pack_exp(1'b0, 5'd0, 1'b0, 1'b1, dec ? 4'(15 - r) : 4'(r), 1'b0, 1'b1, 1'b0);
         end else if (m == base + 17) begin
            e = pack_exp(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
         end else begin
            e = pack_exp(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
         end
         a = obs();
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, m, a, e);
         end
         if (m == toggle_at) bus_if.decrypt = ~bus_if.decrypt;
         if (repress && m == 5) bus_if.button = 1'b0;
         if (repress && m == 7) bus_if.button = 1'b1;
      end
   endtask

   task automatic release_button();
      bus_if.button = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [14:0] a;
      reset = 1'b0;
      bus_if.button = 1'b0;
      bus_if.decrypt = 1'b0;
      bus_if.key_new = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a = obs();
      tests_run++;
      if (a !== 15'd0) begin
         tests_failed++;
         $display("FAIL reset_hold: got %b expected %b", a, 15'd0);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      a = obs();
      tests_run++;
      if (a !== 15'd0) begin
         tests_failed++;
         $display("FAIL reset_idle: got %b expected %b", a, 15'd0);
      end
   endtask

   task automatic test_first_run_held();
      logic [14:0] a;
      logic [14:0] e;
      bus_if.key_new = 1'b1;
      bus_if.decrypt = 1'b0;
      observe_run(1'b1, 1'b0, -1, 1'b0, 1000, "enc_keygen");
      bus_if.key_new = 1'b0;
      e = pack_exp(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      // Button kept high well past 100 cycles: must not restart.
      for (int i = 0; i < 65; i++) begin
         @(posedge clk); #1;
         a = obs();
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL held_button cycle %0d: got %b expected %b", i, a, e);
         end
      end
      release_button();
   endtask

   task automatic test_no_keygen();
      bus_if.key_new = 1'b0;
      bus_if.decrypt = 1'b0;
      observe_run(1'b0, 1'b0, -1, 1'b0, 1000, "enc_nokeygen");
      release_button();
   endtask

   task automatic test_decrypt_toggle();
      bus_if.key_new = 1'b0;
      bus_if.decrypt = 1'b1;
      observe_run(1'b0, 1'b1, 6, 1'b0, 1000, "dec_toggle");
      bus_if.decrypt = 1'b0;
      release_button();
   endtask

   task automatic test_reset_abort();
      logic [14:0] a;
      bus_if.key_new = 1'b0;
      bus_if.decrypt = 1'b0;
      // m=8 is the cycle showing rnd_idx 7.
      observe_run(1'b0, 1'b0, -1, 1'b0, 8, "abort_prefix");
      reset = 1'b0;
      bus_if.button = 1'b0;
      @(posedge clk); #1;
      a = obs();
      tests_run++;
      if (a !== 15'd0) begin
         tests_failed++;
         $display("FAIL abort_reset: got %b expected %b", a, 15'd0);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      a = obs();
      tests_run++;
      if (a !== 15'd0) begin
         tests_failed++;
         $display("FAIL abort_idle: got %b expected %b", a, 15'd0);
      end
      // key_ok was cleared, so keygen runs even with key_new low.
      observe_run(1'b1, 1'b0, -1, 1'b0, 1000, "abort_rerun_keygen");
      release_button();
   endtask

   task automatic test_press_during_keygen();
      logic [14:0] a;
      logic [14:0] e;
      bus_if.key_new = 1'b1;
      bus_if.decrypt = 1'b0;
      observe_run(1'b1, 1'b0, -1, 1'b1, 1000, "repress_keygen");
      bus_if.key_new = 1'b0;
      bus_if.button = 1'b0;
      e = pack_exp(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         a = obs();
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL no_queued_run cycle %0d: got %b expected %b", i, a, e);
         end
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_first_run_held();
      test_no_keygen();
      test_decrypt_toggle();
      test_reset_abort();
      test_press_during_keygen();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
